// File: rtl/bcd_seven_segment.sv
// Registered BCD-to-seven-segment decoder with lamp test, forced blank,
// ripple (leading-zero) blanking and an invalid-code flag.
module bcd_seven_segment #(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit TAIL_6     = 1'b1,
    parameter bit TAIL_9     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    input  logic       lamp_test,
    input  logic       blank,
    input  logic       rbi,
    output logic [6:0] out,
    output logic       rbo,
    output logic       err
);

    logic [6:0] seg_dec;
    logic [6:0] seg_nxt;
    logic       rbo_nxt;
    logic       err_nxt;

    // Segment order {a,b,c,d,e,f,g}, active-high
    always_comb begin
        seg_dec = 7'h00;
        case (in)
            4'd0: seg_dec = 7'h7E;
            4'd1: seg_dec = 7'h30;
            4'd2: seg_dec = 7'h6D;
            4'd3: seg_dec = 7'h79;
            4'd4: seg_dec = 7'h33;
            4'd5: seg_dec = 7'h5B;
            4'd6: seg_dec = TAIL_6 ? 7'h5F : 7'h1F;
            4'd7: seg_dec = 7'h70;
            4'd8: seg_dec = 7'h7F;
            4'd9: seg_dec = TAIL_9 ? 7'h7B : 7'h73;
            default: seg_dec = 7'h00;
        endcase
    end

    always_comb begin
        seg_nxt = seg_dec;
        rbo_nxt = 1'b0;
        err_nxt = 1'b0;
        if (lamp_test) begin
            seg_nxt = 7'h7F;
        end else if (blank) begin
            seg_nxt = 7'h00;
        end else if (rbi && (in == 4'd0)) begin
            seg_nxt = 7'h00;
            rbo_nxt = 1'b1;
        end else if (in > 4'd9) begin
            seg_nxt = 7'h00;
            err_nxt = 1'b1;
        end
    end

    // Reset value is "all segments dark" in the configured polarity
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= ACTIVE_LOW ? 7'h7F : 7'h00;
            rbo <= 1'b0;
            err <= 1'b0;
        end else begin
            out <= ACTIVE_LOW ? ~seg_nxt : seg_nxt;
            rbo <= rbo_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_seven_segment.sv
// Self-checking bench: directed plan plus random stimulus against a table model,
// on a default instance and an inverted/no-tail instance sharing inputs.
module tb_bcd_seven_segment;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in;
    logic       lamp_test, blank, rbi;
    logic [6:0] out0, out1;
    logic       rbo0, rbo1, err0, err1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    bcd_seven_segment u_dut0 (
        .clk(clk), .rst(rst), .in(in), .lamp_test(lamp_test), .blank(blank),
        .rbi(rbi), .out(out0), .rbo(rbo0), .err(err0)
    );

    bcd_seven_segment #(.ACTIVE_LOW(1'b1), .TAIL_6(1'b0), .TAIL_9(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in(in), .lamp_test(lamp_test), .blank(blank),
        .rbi(rbi), .out(out1), .rbo(rbo1), .err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {out[6:0], rbo, err}
    function automatic logic [8:0] model(input bit al, input bit t6, input bit t9,
                                         input bit r, input int d, input bit lt,
                                         input bit bl, input bit ri);
        logic [6:0] tbl [10];
        logic [6:0] pat;
        bit         rb, er;
        tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        if (!t6) tbl[6] = 7'h1F;
        if (!t9) tbl[9] = 7'h73;
        rb = 0; er = 0;
        if (r)                 pat = 7'h00;
        else if (lt)           pat = 7'h7F;
        else if (bl)           pat = 7'h00;
        else if (ri && d == 0) begin pat = 7'h00; rb = 1; end
        else if (d >= 10)      begin pat = 7'h00; er = 1; end
        else                   pat = tbl[d];
        if (al) pat = ~pat;
        return {pat, rb, er};
    endfunction

    // Inputs are set at negedge; one rising edge later both instances are compared
    task automatic cyc(input string tag);
        logic [8:0] e0, e1;
        e0 = model(0, 1, 1, rst, int'(in), lamp_test, blank, rbi);
        e1 = model(1, 0, 0, rst, int'(in), lamp_test, blank, rbi);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".d0"}, {out0, rbo0, err0}, e0);
        chk({tag, ".d1"}, {out1, rbo1, err1}, e1);
    endtask

    task automatic drv(input bit r, input logic [3:0] d, input bit lt, input bit bl, input bit ri);
        rst = r; in = d; lamp_test = lt; blank = bl; rbi = ri;
    endtask

    initial begin
        drv(1, 4'd8, 1, 0, 0);
        @(negedge clk);
        cyc("rst_init");
        // Explicit reset values, independent of the model
        chk("rst_out0", out0, 7'h00);
        chk("rst_out1", out1, 7'h7F);

        // Digit sweep, each held four cycles
        for (int d = 0; d < 10; d++) begin
            drv(0, 4'(d), 0, 0, 0);
            for (int k = 0; k < 4; k++) cyc($sformatf("sweep%0d", d));
        end
        drv(0, 4'd6, 0, 0, 0); cyc("d6");
        chk("d6_notail_inv", out1, 7'h60);
        drv(0, 4'd9, 0, 0, 0); cyc("d9");
        chk("d9_notail_inv", out1, 7'h0C);

        for (int d = 10; d < 16; d++) begin
            drv(0, 4'(d), 0, 0, 0); cyc($sformatf("inv%0d", d));
        end
        drv(0, 4'd3, 0, 0, 0); cyc("inv_recover");
        chk("recover_out", out0, 7'h79);

        drv(0, 4'd5, 1, 1, 0); cyc("lt_over_blank");
        drv(0, 4'd5, 0, 1, 0); cyc("blank");
        drv(0, 4'd5, 0, 0, 0); cyc("unblank");
        chk("unblank_out", out0, 7'h5B);
        drv(0, 4'd12, 1, 0, 1); cyc("lt_over_err");
        drv(0, 4'd0, 0, 1, 1); cyc("blank_over_rbi");

        drv(0, 4'd0, 0, 0, 1); cyc("rbi_zero");
        chk("rbi_zero_rbo", rbo0, 1'b1);
        drv(0, 4'd4, 0, 0, 1); cyc("rbi_four");
        drv(0, 4'd0, 0, 0, 0); cyc("zero_no_rbi");
        drv(0, 4'd11, 0, 0, 1); cyc("rbi_invalid");

        drv(1, 4'd7, 1, 0, 0); cyc("rst_mid");
        drv(0, 4'd7, 0, 0, 0); cyc("rst_release");

        for (int i = 0; i < 400; i++) begin
            drv(($urandom_range(15) == 0), 4'($urandom_range(15)),
                ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                1'($urandom_range(1)));
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
